// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift controller: operation select
// values and FSM state encoding.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift1_step.sv
// Purely combinational single-bit shift stage. The controller applies this
// stage once per clock to build up a variable-distance shift.
module shift1_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r_next,
    output logic             bout
);

    // One-bit step: left ops lose the MSB, right ops lose the LSB.
    always_comb begin
        r_next = r;
        bout   = 1'b0;
        case (op)
            OP_SLL: begin
                r_next = {r[WIDTH-2:0], 1'b0};
                bout   = r[WIDTH-1];
            end
            OP_SRL: begin
                r_next = {1'b0, r[WIDTH-1:1]};
                bout   = r[0];
            end
            OP_SRA: begin
                r_next = {r[WIDTH-1], r[WIDTH-1:1]};
                bout   = r[0];
            end
            OP_ROL: begin
                r_next = {r[WIDTH-2:0], r[WIDTH-1]};
                bout   = r[WIDTH-1];
            end
            default: begin
                r_next = r;
                bout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_16b.sv
// Multi-cycle shift controller. Accepts one request (operand, op, amount) and
// walks a single-bit shift stage once per clock until the amount is used up.
//
// Handshake: start is a request strobe that is accepted only when busy is low
// (state IDLE); it is ignored while busy, including the DONE cycle, and is
// never queued. op/amt/din matter only in the accepting cycle. done is a
// one-cycle pulse marking dout/cout final; the next request can be accepted
// in the cycle after done. dbg_state exposes the FSM state for checkers.
module shift_seq_16b
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [1:0]        op_q,    op_d;
    logic [WIDTH-1:0]  sr_q,    sr_d;
    logic              cout_q,  cout_d;

    logic [WIDTH-1:0]  step_r;
    logic              step_bout;

    shift1_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (sr_q),
        .op     (op_q),
        .r_next (step_r),
        .bout   (step_bout)
    );

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            sr_q    <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sr_q    <= sr_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sr_d    = sr_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = din;
                    op_d    = op;
                    cnt_d   = amt;
                    cout_d  = 1'b0;
                    // A zero amount skips straight to DONE with dout = din.
                    state_d = (amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                sr_d   = step_r;
                cout_d = step_bout;
                cnt_d  = cnt_q - CNT_W'(1);
                // Leave on the final step so the counter never wraps.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are decoded straight from the state register.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dout      = sr_q;
        cout      = cout_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/shift_seq_16b.md
# shift_seq_16b

Multi-cycle shift controller for the 16-bit datapath. It takes one shift request (operand, operation, amount), then applies a single-bit shift stage once per clock until the requested amount is reached. It reports the result, the last bit shifted out, and a one-cycle completion pulse. It sits beside the ALU and lets the datapath implement variable shifts without a barrel shifter.

## Interface
Parameters:
- WIDTH, default 16: operand width.
- CNT_W, default 4: width of the shift amount; the maximum amount is 2^CNT_W − 1.

Ports:
- clk, in, 1: the single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: request strobe; sampled only in IDLE.
- op, in, 2: operation select. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROL.
- amt, in, CNT_W: number of single-bit steps.
- din, in, WIDTH: operand.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse when the result is valid.
- dout, out, WIDTH: result register.
- cout, out, 1: last bit shifted out. It is 0 when amt = 0.

## Operation
States:
- IDLE
  - On start = 1: latch din into the shift register, op into an op register, and amt into a counter. Clear cout.
  - Go to SHIFT if amt ≠ 0, else to DONE.
  - With start = 0: stay in IDLE.
- SHIFT
  - Each cycle: shift register ← one-bit step of the shift register; counter ← counter − 1; cout ← the bit shifted out.
  - When counter = 1 (the final step is taken this cycle), go to DONE.
- DONE
  - done = 1 for this cycle only.
  - Unconditionally go to IDLE.

One-bit step definitions:
- SLL: {r[14:0], 0}; cout = r[15].
- SRL: {0, r[15:1]}; cout = r[0].
- SRA: {r[15], r[15:1]}; cout = r[0].
- ROL: {r[14:0], r[15]}; cout = r[15].

Outputs and rules:
- dout is the shift register itself. It holds its value through IDLE until the next accepted start, and shows intermediate values during SHIFT.
- start is ignored while busy, including the DONE cycle. Requests are never queued.
- op, amt and din are don't-care except in the cycle start is accepted.
- The counter never wraps: SHIFT is left exactly when counter = 1.

## Timing
- Request accepted in cycle 0 (start high in IDLE):
  - cycles 1..amt are SHIFT;
  - cycle amt+1 is DONE, with done = 1 and final dout and cout.
- amt = 0: done is asserted in cycle 1, with dout = din and cout = 0.
- The earliest next accepted start is cycle amt+2, i.e. one cycle after done.
- Reset values: state IDLE, busy 0, done 0, dout 0, cout 0, counter 0.
- Reset asserted mid-operation:
  - the next edge forces all reset values;
  - no done pulse is produced for the aborted request.
- If reset and start are both high, reset wins and the request is dropped.

## Structure
- Shared package `shift_pkg`:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROL;
  - state encoding: S_IDLE, S_SHIFT, S_DONE.
- Sub-module `shift1_step`:
  - purely combinational one-bit stage, parameterized by WIDTH;
  - inputs: r, op. Outputs: next r, shifted-out bit.
- The controller holds only the FSM, counter, op register, shift register and cout register.

## Test plan
- SLL: din = 16'h0001, amt = 4, start in cycle 0 → busy in cycles 1–5; done only in cycle 5; dout = 16'h0010; cout = 0.
- SRA with sign: din = 16'h8001, amt = 1 → done in cycle 2; dout = 16'hC000; cout = 1. Repeat with op = SRL → dout = 16'h4000; cout = 1.
- ROL full: din = 16'hA5A5, amt = 15 → done in cycle 16; dout = 16'hD2D2; cout = 0.
- Zero amount, then back-to-back requests:
  - amt = 0, din = 16'h1234 → done in cycle 1, dout = 16'h1234, cout = 0;
  - start held high continuously → a second request is accepted in cycle 2, and start in the DONE cycle is ignored.
- Reset mid-operation: SLL amt = 10 started, reset high in cycle 3 → from cycle 4 busy = 0, dout = 0, no done pulse. A new SRL request with din = 16'h0100, amt = 8 completes with dout = 16'h0001.
